spi_reg_peripheral: RTL
=======================

SPI_REG_PERIPHERAL -- requirements
Module: spi_reg_peripheral

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flip-flop stages on each SPI input synchronizer (legal values 2-3).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sclk_i  input  1  SPI serial clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005 copi_i  input  1  SPI controller-out/peripheral-in data.
REQ-006 ncs_i  input  1  SPI chip select, active-low.
REQ-007 cipo_o  output  1  SPI peripheral-out data; driven by readback logic when SPI_READBACK_EN is defined, otherwise constant 0.
REQ-008 en_reg_out_7_0  output  8  register 0x00, output-enable bits for dedicated outputs [7:0].
REQ-009 en_reg_out_15_8  output  8  register 0x01, output-enable bits for bidirectional outputs [7:0].
REQ-010 en_reg_pwm_7_0  output  8  register 0x02, PWM-mode select for dedicated outputs [7:0].
REQ-011 en_reg_pwm_15_8  output  8  register 0x03, PWM-mode select for bidirectional outputs [7:0].
REQ-012 pwm_duty_cycle  output  8  register 0x04, PWM duty (0x00 = 0%, 0xFF = 100%).
REQ-013 txn_done_o  output  1  one-clk pulse when a valid write commits.

Function
REQ-014 sclk_i, copi_i and ncs_i SHALL each pass through a SYNC_STAGES-deep synchronizer; all protocol logic SHALL use only the synchronized copies.
REQ-015 Edge detection SHALL compare the last synchronizer stage with one additional delay flop, giving one-clk pulses for sclk rise, sclk fall, ncs fall and ncs rise.
REQ-016 FSM states: IDLE (ncs high), SHIFT (ncs low, capturing), DONE (evaluate and commit, one clk).
REQ-017 IDLE->SHIFT on ncs fall: clear the 5-bit bit counter and the 16-bit shift register.
REQ-018 In SHIFT, on each sclk rise, shift copi into the LSB of the shift register and increment the counter, saturating at 17.
REQ-019 Frame format MSB-first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-020 SHIFT->DONE on ncs rise; DONE->IDLE unconditionally after one clk.
REQ-021 In DONE, commit data to the addressed register only if counter == 16, R/W == 1 and address <= 0x04; registers update on the clk edge leaving DONE and txn_done_o pulses on that same clk.
REQ-022 Frames with counter != 16 (short or long), R/W == 0, or address > 0x04 SHALL be discarded with no register change and no txn_done_o.
REQ-023 Sclk edges while in IDLE SHALL be ignored.
REQ-024 Coincident sclk rise and ncs rise in the same clk: the sclk rise SHALL be ignored.
REQ-025 Latency: a register output changes 2 clks after the synchronized ncs rise, i.e. SYNC_STAGES+2 clks after the raw ncs_i rise.
REQ-026 Register outputs SHALL hold their value at all other times.

Reset
REQ-027 While rst is high on a clk edge: all five registers = 0x00, cipo_o = 0, txn_done_o = 0, FSM = IDLE, counter = 0, shift register = 0, synchronizer and edge flops = idle levels (sclk 0, ncs 1, copi 0).
REQ-028 rst asserted mid-frame SHALL abort the frame; after rst deasserts, the block SHALL wait for a fresh ncs fall.

Configuration
REQ-029 Macro SPI_READBACK_EN defined: a frame with R/W == 0 is a read; after the 8th sclk rise, load the addressed register value (0x00 if address > 0x04) into an 8-bit output shifter and drive its MSB on cipo_o; on each later sclk fall, shift left; cipo_o = 0 in IDLE; reads never modify registers and never pulse txn_done_o.
REQ-030 Macro SPI_READBACK_EN undefined: no output shifter is built, cipo_o is constant 0, and reads are discarded per REQ-022.

Verification
REQ-031 Write frame 0x80F0 (addr 0x00, data 0xF0) at sclk = clk/8 -> en_reg_out_7_0 = 0xF0 and a single txn_done_o pulse; all other registers stay 0x00.
REQ-032 Write frame 0x8480 -> pwm_duty_cycle = 0x80; then write frame 0x85AA (addr 0x05) -> no register change and no txn_done_o.
REQ-033 15-bit frame, then 17-bit frame, each carrying 0x8155 -> en_reg_out_15_8 remains 0x00.
REQ-034 Assert rst after 9 bits of frame 0x82FF, then send the full frame 0x8233 -> en_reg_pwm_7_0 = 0x33 and never 0xFF.
REQ-035 SPI_READBACK_EN defined: write 0x83C3, then read frame 0x0300 -> cipo_o presents 1,1,0,0,0,0,1,1 over bits 9-16; undefined: cipo_o stays 0 throughout.

Source files
------------

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: SPI mode-0 write port into five 8-bit control registers; SPI_READBACK_EN adds register readback on cipo_o.
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic       cipo_o,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic sclk_dly_q, ncs_dly_q;
    logic sclk_s, copi_s, ncs_s, sclk_rise, ncs_fall, ncs_rise;
    logic [4:0] cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d;
    logic [7:0] regs_q [0:4];
    logic txn_q, commit;
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign ncs_fall = ~ncs_s & ncs_dly_q;
    assign ncs_rise = ncs_s & ~ncs_dly_q;
    assign en_reg_out_7_0 = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0 = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle = regs_q[4];
    assign txn_done_o = txn_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sh_d = sh_q;
        commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d = '0;
                    sh_d = '0;
                end
            end
            SHIFT: begin
                // ncs rise wins over a coincident sclk rise
                if (ncs_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    sh_d = {sh_q[14:0], copi_s};
                    cnt_d = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                commit = (cnt_q == 5'd16) && sh_q[15] && (sh_q[14:8] <= 7'd4);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q <= '1;
            sclk_dly_q <= 1'b0;
            ncs_dly_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            txn_q <= 1'b0;
            for (int i = 0; i < 5; i++) regs_q[i] <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
            ncs_sync_q <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
            sclk_dly_q <= sclk_s;
            ncs_dly_q <= ncs_s;
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            txn_q <= commit;
            if (commit) regs_q[sh_q[10:8]] <= sh_q[7:0];
        end
    end
`ifdef SPI_READBACK_EN
    logic [7:0] osh_q, rd_val;
    logic [6:0] rd_addr;
    logic sclk_fall, rd_load;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign rd_addr = {sh_q[5:0], copi_s};
    assign rd_val = (rd_addr <= 7'd4) ? regs_q[rd_addr[2:0]] : 8'h00;
    assign rd_load = (state_q == SHIFT) && !ncs_rise && sclk_rise && (cnt_q == 5'd7) && !sh_q[6];
    assign cipo_o = (state_q != IDLE) & osh_q[7];
    // the fall right after the load keeps the MSB on the line for bit 9
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) osh_q <= '0;
        else if (rd_load) osh_q <= rd_val;
        else if (state_q == SHIFT && sclk_fall && cnt_q >= 5'd9) osh_q <= {osh_q[6:0], 1'b0};
    end
`else
    assign cipo_o = 1'b0;
`endif
endmodule
